// File: rtl/reg4_serial_tx.sv
`timescale 1ns/1ps
// Purpose: parallel-in, serial-out frame transmitter (start 0, DATA_W bits LSB-first, stop 1).
// Latency: tx shows the start bit from the accepting edge; done pulses (DATA_W+2)*CLKS_PER_BIT cycles later.
// Backpressure: ready is low for the whole frame; a load while not ready is dropped, not queued.
// Ports: clk/rst_n (async active-low); load+d is the accept handshake, qualified by ready;
//        tx is the idle-high serial line; busy is high during START/DATA/STOP; done is a 1-cycle end pulse.
module reg4_serial_tx #(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic              ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] I_LAST = IW'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] shift, shift_n;
    logic [IW-1:0]     idx, idx_n;
    logic [TW-1:0]     timer, timer_n;
    logic              tx_n, ready_n, busy_n, done_n;
    logic              bit_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            shift <= '0;
            idx   <= '0;
            timer <= '0;
            tx    <= 1'b1;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            shift <= shift_n;
            idx   <= idx_n;
            timer <= timer_n;
            tx    <= tx_n;
            ready <= ready_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        shift_n = shift;
        idx_n   = idx;
        timer_n = timer;
        done_n  = 1'b0;
        // With CLKS_PER_BIT=1 the timer is a constant 0 and every cycle is a bit end.
        bit_end = (timer == T_LAST);

        case (state)
            IDLE: begin
                if (load) begin
                    state_n = START;
                    shift_n = d;
                    idx_n   = '0;
                    timer_n = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    timer_n = '0;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    timer_n = '0;
                    shift_n = shift >> 1;
                    if (idx == I_LAST) begin
                        state_n = STOP;
                    end else begin
                        idx_n = idx + IW'(1);
                    end
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_n = IDLE;
                    timer_n = '0;
                    done_n  = 1'b1;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
        endcase

        // Outputs are decoded from the next state so the registered copies line up
        // with the state register on the same edge.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            default: tx_n = 1'b1;
        endcase
        ready_n = (state_n == IDLE);
        busy_n  = (state_n != IDLE);
    end

endmodule

// File: tb/tb_reg4_serial_tx.sv
`timescale 1ns/1ps
module tb_reg4_serial_tx;

    localparam int DW = 4;
    // Per-cycle observation vector: {tx, ready, busy, done}
    localparam logic [3:0] IDLE_V = 4'b1100;
    localparam logic [3:0] DONE_V = 4'b1101;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          load_a = 1'b0, load_b = 1'b0;
    logic [DW-1:0] d_a = '0, d_b = '0;
    logic          ready_a, tx_a, busy_a, done_a;
    logic          ready_b, tx_b, busy_b, done_b;

    int            checks = 0;
    int            failures = 0;
    logic [3:0]    q_a[$];
    logic [3:0]    q_b[$];
    logic [3:0]    exp_a, exp_b;

    reg4_serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(4)) u_a (
        .clk(clk), .rst_n(rst_n), .load(load_a), .d(d_a),
        .ready(ready_a), .tx(tx_a), .busy(busy_a), .done(done_a)
    );

    reg4_serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(1)) u_b (
        .clk(clk), .rst_n(rst_n), .load(load_b), .d(d_b),
        .ready(ready_b), .tx(tx_b), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected per-cycle vectors for one frame, starting at the cycle after the accepting edge.
    task automatic push_frame(input int inst, input logic [DW-1:0] w, input int c);
        logic       bitv;
        logic [3:0] v;
        for (int b = 0; b < DW + 2; b++) begin
            if (b == 0)       bitv = 1'b0;
            else if (b <= DW) bitv = w[b-1];
            else              bitv = 1'b1;
            v = {bitv, 3'b010};
            for (int k = 0; k < c; k++) begin
                if (inst == 0) q_a.push_back(v);
                else           q_b.push_back(v);
            end
        end
        if (inst == 0) q_a.push_back(DONE_V);
        else           q_b.push_back(DONE_V);
    endtask

    // Scoreboard: compare every cycle on the falling edge; the model accepts a load
    // only when no frame remains in its queue, mirroring the handshake from outside.
    always @(negedge clk) begin
        if (!rst_n) begin
            q_a.delete();
            q_b.delete();
            check("rst_a", {tx_a, ready_a, busy_a, done_a}, IDLE_V);
            check("rst_b", {tx_b, ready_b, busy_b, done_b}, IDLE_V);
        end else begin
            exp_a = (q_a.size() > 0) ? q_a.pop_front() : IDLE_V;
            exp_b = (q_b.size() > 0) ? q_b.pop_front() : IDLE_V;
            check("cyc_a", {tx_a, ready_a, busy_a, done_a}, exp_a);
            check("cyc_b", {tx_b, ready_b, busy_b, done_b}, exp_b);
            if (q_a.size() == 0 && load_a) push_frame(0, d_a, 4);
            if (q_b.size() == 0 && load_b) push_frame(1, d_b, 1);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(10);

        // Single frame 1010
        load_a = 1'b1; d_a = 4'b1010;
        tick(1);
        load_a = 1'b0;
        tick(30);

        // Load while busy must be dropped
        load_a = 1'b1; d_a = 4'b0101;
        tick(1);
        load_a = 1'b0;
        tick(5);
        load_a = 1'b1; d_a = 4'b1111;
        tick(1);
        load_a = 1'b0;
        tick(30);

        // Back-to-back with load held high
        load_a = 1'b1; d_a = 4'b0011;
        tick(1);
        d_a = 4'b1100;
        tick(30);
        load_a = 1'b0;
        tick(30);

        // Reset during DATA bit 2
        load_a = 1'b1; d_a = 4'b1011;
        tick(1);
        load_a = 1'b0;
        tick(13);
        check("pre_rst_busy", busy_a, 1);
        rst_n = 1'b0;
        #1;
        check("async_tx", tx_a, 1);
        check("async_ready", ready_a, 1);
        check("async_busy", busy_a, 0);
        check("async_done", done_a, 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        load_a = 1'b1; d_a = 4'b0110;
        tick(1);
        load_a = 1'b0;
        tick(30);

        // One-cycle bit instance: single frame, then held load
        load_b = 1'b1; d_b = 4'b1001;
        tick(1);
        load_b = 1'b0;
        tick(10);
        load_b = 1'b1; d_b = 4'b0110;
        tick(16);
        load_b = 1'b0;
        tick(10);

        check("q_a_drained", q_a.size(), 0);
        check("q_b_drained", q_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
